// File: rtl/jpeg_marker_ctrl_if.sv
// Bit-buffer window and segment-data bundle of the JPEG marker sequencer.
interface jpeg_marker_ctrl_if;
  logic        DataInStart;
  logic [31:0] DataIn;
  logic        DataInEnable;
  logic        DataInEnd;
  logic        UseByte;
  logic        UseWord;
  logic        ImageEnable;
  logic        SegValid;
  logic [7:0]  SegMarker;
  logic [7:0]  SegData;
  logic        SegFirst;
  logic        Done;
  logic        Error;

  // Buffer/host side: supplies the window, consumes Use* and segment data.
  modport master (
    output DataInStart, DataIn, DataInEnable, DataInEnd,
    input  UseByte, UseWord, ImageEnable, SegValid, SegMarker, SegData,
    input  SegFirst, Done, Error
  );

  // Sequencer side.
  modport slave (
    input  DataInStart, DataIn, DataInEnable, DataInEnd,
    output UseByte, UseWord, ImageEnable, SegValid, SegMarker, SegData,
    output SegFirst, Done, Error
  );
endinterface

// File: rtl/jpeg_marker_ctrl.sv
// JPEG header/marker sequencer sitting on the bit-buffer output: walks
// SOI, length-prefixed segments and SOS, forwards segment payload bytes to
// the table loaders and hands the buffer to the entropy decoder until EOI.
module jpeg_marker_ctrl #(
  parameter bit          SKIP_APP = 1'b1,
  parameter int unsigned MAX_LEN  = 32'h0000_FFFF
) (
  input logic               clk,
  input logic               rst,
  jpeg_marker_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOI,
    ST_MARK,
    ST_LEN,
    ST_PAY,
    ST_IMG,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_rem, w_rem_nxt;
  logic [7:0]  r_marker, w_marker_nxt;
  logic        r_first, w_first_nxt;
  logic        r_use_byte, w_use_byte_nxt;
  logic        r_use_word, w_use_word_nxt;
  logic        r_seg_valid, w_seg_valid_nxt;
  logic        r_seg_first, w_seg_first_nxt;
  logic [7:0]  r_seg_data, w_seg_data_nxt;
  logic        r_image, w_image_nxt;
  logic        r_done, w_done_nxt;
  logic        r_error, w_error_nxt;

  logic        w_sample;
  logic        w_skip;
  logic [15:0] w_word;
  logic [7:0]  w_byte0;
  logic [7:0]  w_byte1;
  logic        w_unused_window;

  // A Use* pulse in flight means the window is stale this cycle.
  assign w_sample = bus.DataInEnable && !r_use_byte && !r_use_word;
  assign w_word   = bus.DataIn[31:16];
  assign w_byte0  = bus.DataIn[31:24];
  assign w_byte1  = bus.DataIn[23:16];
  assign w_skip   = SKIP_APP && ((r_marker[7:4] == 4'hE) || (r_marker == 8'hFE));

  // Only the two leading bytes of the window are ever inspected.
  assign w_unused_window = &{1'b0, bus.DataIn[15:0]};

  // Next-state, counter and registered-output computation.
  always_comb begin
    w_state_nxt     = r_state;
    w_rem_nxt       = r_rem;
    w_marker_nxt    = r_marker;
    w_first_nxt     = r_first;
    w_use_byte_nxt  = 1'b0;
    w_use_word_nxt  = 1'b0;
    w_seg_valid_nxt = 1'b0;
    w_seg_first_nxt = 1'b0;
    w_seg_data_nxt  = r_seg_data;
    w_image_nxt     = 1'b0;
    w_done_nxt      = 1'b0;
    w_error_nxt     = 1'b0;

    unique case (r_state)
      ST_IDLE: w_state_nxt = ST_SOI;

      ST_SOI: begin
        if (w_sample) begin
          if (w_word == 16'hFFD8) begin
            w_use_word_nxt = 1'b1;
            w_state_nxt    = ST_MARK;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
      end

      ST_MARK: begin
        if (w_sample) begin
          if (w_byte0 != 8'hFF) begin
            w_state_nxt = ST_ERR;
          end else if (w_byte1 == 8'hFF) begin
            w_use_byte_nxt = 1'b1;
          end else if (w_byte1 == 8'hD9) begin
            w_use_word_nxt = 1'b1;
            w_state_nxt    = ST_DONE;
          end else if (w_byte1 inside {[8'hD0:8'hD7], 8'h01}) begin
            w_use_word_nxt = 1'b1;
          end else begin
            w_marker_nxt   = w_byte1;
            w_use_word_nxt = 1'b1;
            w_state_nxt    = ST_LEN;
          end
        end
      end

      ST_LEN: begin
        if (w_sample) begin
          if ((w_word < 16'd2) || (32'(w_word) > MAX_LEN)) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_rem_nxt      = w_word - 16'd2;
            w_use_word_nxt = 1'b1;
            w_first_nxt    = 1'b1;
            if (w_word == 16'd2) begin
              w_state_nxt = (r_marker == 8'hDA) ? ST_IMG : ST_MARK;
            end else begin
              w_state_nxt = ST_PAY;
            end
          end
        end
      end

      ST_PAY: begin
        if (w_sample) begin
          w_use_byte_nxt = 1'b1;
          w_first_nxt    = 1'b0;
          if (r_rem != '0) begin
            w_rem_nxt = r_rem - 16'd1;
          end
          if (!w_skip) begin
            w_seg_valid_nxt = 1'b1;
            w_seg_data_nxt  = w_byte0;
            w_seg_first_nxt = r_first;
          end
          if (r_rem <= 16'd1) begin
            w_state_nxt = (r_marker == 8'hDA) ? ST_IMG : ST_MARK;
          end
        end
      end

      ST_IMG: begin
        if (bus.DataInEnable && bus.DataInEnd) begin
          w_state_nxt = ST_MARK;
        end
      end

      ST_DONE: w_state_nxt = ST_DONE;

      ST_ERR: w_state_nxt = ST_ERR;
    endcase

    // ImageEnable and Done trail state entry by one cycle; Error rises with it.
    w_image_nxt = (r_state == ST_IMG);
    w_done_nxt  = (r_state == ST_DONE);
    w_error_nxt = (w_state_nxt == ST_ERR);

    // DataInStart outranks every event: every next value returns to reset.
    if (bus.DataInStart) begin
      w_state_nxt     = ST_IDLE;
      w_rem_nxt       = '0;
      w_marker_nxt    = '0;
      w_first_nxt     = 1'b0;
      w_use_byte_nxt  = 1'b0;
      w_use_word_nxt  = 1'b0;
      w_seg_valid_nxt = 1'b0;
      w_seg_first_nxt = 1'b0;
      w_seg_data_nxt  = '0;
      w_image_nxt     = 1'b0;
      w_done_nxt      = 1'b0;
      w_error_nxt     = 1'b0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_marker    <= '0;
      r_first     <= 1'b0;
      r_use_byte  <= 1'b0;
      r_use_word  <= 1'b0;
      r_seg_valid <= 1'b0;
      r_seg_first <= 1'b0;
      r_seg_data  <= '0;
      r_image     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_marker    <= w_marker_nxt;
      r_first     <= w_first_nxt;
      r_use_byte  <= w_use_byte_nxt;
      r_use_word  <= w_use_word_nxt;
      r_seg_valid <= w_seg_valid_nxt;
      r_seg_first <= w_seg_first_nxt;
      r_seg_data  <= w_seg_data_nxt;
      r_image     <= w_image_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign bus.UseByte     = r_use_byte;
  assign bus.UseWord     = r_use_word;
  assign bus.ImageEnable = r_image;
  assign bus.SegValid    = r_seg_valid;
  assign bus.SegMarker   = r_marker;
  assign bus.SegData     = r_seg_data;
  assign bus.SegFirst    = r_seg_first;
  assign bus.Done        = r_done;
  assign bus.Error       = r_error;

endmodule

// File: tb/tb_jpeg_marker_ctrl.sv
// Bench for jpeg_marker_ctrl: a byte-stream buffer model feeds two
// instances (SKIP_APP=1 and SKIP_APP=0); expected payload, consumption and
// final status come from a direct walk of the byte stream.
module tb_jpeg_marker_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jpeg_marker_ctrl_if if1 ();
  jpeg_marker_ctrl_if if0 ();

  jpeg_marker_ctrl #(.SKIP_APP(1'b1)) u_dut_skip (.clk(clk), .rst(rst), .bus(if1));
  jpeg_marker_ctrl #(.SKIP_APP(1'b0)) u_dut_all  (.clk(clk), .rst(rst), .bus(if0));

  int unsigned errors = 0;
  int unsigned checks = 0;

  byte unsigned s[$];              // byte stream presented by the buffer
  logic [16:0]  q_skip[$];         // {marker, data, first} expected, SKIP_APP=1
  logic [16:0]  q_all[$];          // expected, SKIP_APP=0
  int           exp_pos;
  logic         exp_done, exp_err;
  int           ptr, ptr0;
  int           en_mode;
  logic         cur_en;
  logic         prev_sample, prev_sample0;
  logic [7:0]   mk_tab [9] = '{8'hDB, 8'hC4, 8'hC0, 8'hDD, 8'hE0, 8'hE5, 8'hEF, 8'hFE, 8'hDA};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] sb(input int i);
    if (i >= 0 && i < s.size()) return s[i];
    return 8'h00;
  endfunction

  function automatic logic at_eoi(input int p);
    return (sb(p) == 8'hFF) && (sb(p + 1) == 8'hD9);
  endfunction

  task automatic push16(input logic [15:0] w);
    s.push_back(w[15:8]);
    s.push_back(w[7:0]);
  endtask

  task automatic set_in(input logic st, input logic [31:0] d, input logic en, input logic e);
    if1.DataInStart = st; if1.DataIn = d; if1.DataInEnable = en; if1.DataInEnd = e;
    if0.DataInStart = st; if0.DataIn = d; if0.DataInEnable = en; if0.DataInEnd = e;
  endtask

  // Reference: walk the marker stream directly.
  task automatic model();
    int          pos;
    int          len;
    logic [7:0]  m;
    logic [7:0]  b;
    q_skip.delete();
    q_all.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    pos      = 0;
    if ({sb(0), sb(1)} != 16'hFFD8) begin
      exp_err = 1'b1;
    end else begin
      pos = 2;
      for (int g = 0; g < 10000; g++) begin
        if (sb(pos) != 8'hFF) begin exp_err = 1'b1; break; end
        b = sb(pos + 1);
        if (b == 8'hFF) pos += 1;
        else if (b == 8'hD9) begin pos += 2; exp_done = 1'b1; break; end
        else if ((b >= 8'hD0 && b <= 8'hD7) || b == 8'h01) pos += 2;
        else begin
          m   = b;
          pos += 2;
          len = int'({sb(pos), sb(pos + 1)});
          if (len < 2) begin exp_err = 1'b1; break; end
          pos += 2;
          for (int i = 0; i < len - 2; i++) begin
            q_all.push_back({m, sb(pos + i), (i == 0)});
            if (!((m >= 8'hE0 && m <= 8'hEF) || m == 8'hFE))
              q_skip.push_back({m, sb(pos + i), (i == 0)});
          end
          pos += len - 2;
          if (m == 8'hDA)
            while (!at_eoi(pos) && pos < s.size()) pos++;
        end
      end
    end
    exp_pos = pos;
  endtask

  task automatic drive();
    logic        en;
    logic [31:0] d;
    case (en_mode)
      0:       en = 1'b1;
      1:       en = !cur_en;
      default: en = ($urandom_range(0, 3) != 0);
    endcase
    d = en ? {sb(ptr), sb(ptr + 1), sb(ptr + 2), sb(ptr + 3)} : $urandom();
    set_in(1'b0, d, en, at_eoi(ptr));
    cur_en = en;
  endtask

  task automatic step();
    logic        ub, uw, ub0, uw0;
    logic [31:0] w;
    @(posedge clk); #1;
    ub = if1.UseByte; uw = if1.UseWord; ub0 = if0.UseByte; uw0 = if0.UseWord;
    chk("use_exclusive_skip", 32'(ub & uw), 32'd0);
    chk("use_exclusive_all", 32'(ub0 & uw0), 32'd0);
    if (ub || uw)   chk("use_needs_sample_skip", 32'(prev_sample), 32'd1);
    if (ub0 || uw0) chk("use_needs_sample_all", 32'(prev_sample0), 32'd1);
    if (if1.SegValid) begin
      chk("seg_with_usebyte_skip", 32'(ub), 32'd1);
      w = (q_skip.size() > 0) ? {15'd0, q_skip.pop_front()} : '1;
      chk("seg_skip", {15'd0, if1.SegMarker, if1.SegData, if1.SegFirst}, w);
    end
    if (if0.SegValid) begin
      chk("seg_with_usebyte_all", 32'(ub0), 32'd1);
      w = (q_all.size() > 0) ? {15'd0, q_all.pop_front()} : '1;
      chk("seg_all", {15'd0, if0.SegMarker, if0.SegData, if0.SegFirst}, w);
    end
    ptr  += int'(ub) + 2 * int'(uw);
    ptr0 += int'(ub0) + 2 * int'(uw0);
    // Entropy decoder stand-in: eats one scan byte per cycle while enabled.
    if (if1.ImageEnable && !at_eoi(ptr) && ptr < s.size()) ptr++;
    if (if0.ImageEnable && !at_eoi(ptr0) && ptr0 < s.size()) ptr0++;
    drive();
    prev_sample  = cur_en && !ub && !uw;
    prev_sample0 = cur_en && !ub0 && !uw0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_skip"}, {9'd0, if1.UseByte, if1.UseWord, if1.ImageEnable, if1.SegValid,
        if1.SegMarker, if1.SegData, if1.SegFirst, if1.Done, if1.Error}, 32'd0);
    chk({tag, "_all"}, {9'd0, if0.UseByte, if0.UseWord, if0.ImageEnable, if0.SegValid,
        if0.SegMarker, if0.SegData, if0.SegFirst, if0.Done, if0.Error}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(1'b0, $urandom(), 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset_outputs");
    rst = 1'b1;
  endtask

  task automatic do_start();
    set_in(1'b1, $urandom(), 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, $urandom(), 1'b0, 1'b0);
    chk_quiet("start_outputs");
  endtask

  task automatic run_stream(input int budget, input int abort_after);
    int settle;
    model();
    ptr = 0; ptr0 = 0; settle = -1;
    cur_en = 1'b0;
    drive();
    prev_sample  = cur_en;
    prev_sample0 = cur_en;
    for (int n = 0; n < budget; n++) begin
      step();
      if (abort_after > 0 && n + 1 == abort_after) return;
      if (settle < 0 && (if1.Done || if1.Error)) settle = 6;
      else if (settle > 0) begin
        settle--;
        if (settle == 0) break;
      end
    end
    chk("run_settled", 32'(settle == 0), 32'd1);
    chk("done_skip", 32'(if1.Done), 32'(exp_done));
    chk("error_skip", 32'(if1.Error), 32'(exp_err));
    chk("done_all", 32'(if0.Done), 32'(exp_done));
    chk("error_all", 32'(if0.Error), 32'(exp_err));
    chk("image_idle", {30'd0, if1.ImageEnable, if0.ImageEnable}, 32'd0);
    chk("consumed_skip", ptr, exp_pos);
    chk("consumed_all", ptr0, exp_pos);
    chk("segs_pending", q_skip.size() + q_all.size(), 32'd0);
  endtask

  task automatic build_random();
    int         nseg;
    int         k;
    int         len;
    logic [7:0] m;
    s.delete();
    push16(16'hFFD8);
    nseg = $urandom_range(2, 6);
    for (int j = 0; j < nseg; j++) begin
      k = $urandom_range(0, 9);
      if (k == 0) s.push_back(8'hFF);
      else if (k == 1)
        push16(($urandom_range(0, 8) == 8) ? 16'hFF01 : {8'hFF, 8'hD0 + 8'($urandom_range(0, 7))});
      else begin
        m   = mk_tab[$urandom_range(0, 8)];
        len = $urandom_range(2, 9);
        push16({8'hFF, m});
        push16(16'(len));
        for (int i = 0; i < len - 2; i++) s.push_back(8'($urandom_range(0, 255)));
        if (m == 8'hDA) begin
          repeat ($urandom_range(0, 6)) s.push_back(8'($urandom_range(0, 254)));
          break;
        end
      end
    end
    push16(16'hFFD9);
  endtask

  initial begin
    rst = 1'b0;
    cur_en = 1'b0;
    en_mode = 0;
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    do_reset();

    // SOI then EOI.
    s = '{8'hFF, 8'hD8, 8'hFF, 8'hD9};
    run_stream(200, 0);

    // DQT with three payload bytes.
    do_start();
    s = '{8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00, 8'h05, 8'h00, 8'h11, 8'h22, 8'hFF, 8'hD9};
    run_stream(200, 0);

    // APP0 payload: suppressed on one instance, emitted on the other.
    do_start();
    s = '{8'hFF, 8'hD8, 8'hFF, 8'hE0, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hFF, 8'hD9};
    run_stream(200, 0);

    // SOS with empty header, scan data, EOI.
    do_start();
    s = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h02, 8'h12, 8'h9C, 8'h00, 8'h47, 8'hFF, 8'hD9};
    run_stream(200, 0);

    // Bad SOI, then restart.
    do_start();
    s = '{8'h12, 8'h34, 8'hFF, 8'hD8};
    run_stream(200, 0);

    // Length field below 2.
    do_start();
    s = '{8'hFF, 8'hD8, 8'hFF, 8'hC4, 8'h00, 8'h01, 8'h55, 8'hFF, 8'hD9};
    run_stream(200, 0);

    // Enable toggling every cycle with a reset pulse in the middle of payload.
    do_start();
    en_mode = 1;
    s.delete();
    push16(16'hFFD8); push16(16'hFFDB); push16(16'h0020);
    for (int i = 0; i < 30; i++) s.push_back(8'($urandom_range(0, 255)));
    push16(16'hFFD9);
    run_stream(400, 24);
    do_reset();
    run_stream(400, 0);

    // Random streams with random and toggling enables.
    for (int t = 0; t < 24; t++) begin
      en_mode = (t % 3 == 0) ? 1 : 2;
      build_random();
      do_start();
      run_stream(2000, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_marker_ctrl.md
Name: jpeg_marker_ctrl

Overview:
- Header/marker sequencer that sits directly on the bit-buffer output: DataOut, DataOutEnable and DataOutEnd feed this block.
- Walks the JPEG marker stream one way (SOI, length-prefixed segments, SOS) and consumes it with UseByte/UseWord pulses.
- Emits segment payload bytes to the table loaders (DQT/DHT/SOF/DRI).
- On SOS completion, raises ImageEnable and hands the buffer to the entropy decoder until EOI is seen.

Parameters:
- SKIP_APP, 1: when 1, payload of APPn (FFE0-FFEF) and COM (FFFE) segments is consumed but not emitted on SegValid.
- MAX_LEN, 16'hFFFF: a segment length field greater than this value is an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- DataInStart  in  1  synchronous restart; clears FSM, counters and Error.
- DataIn  in  32  bit-buffer window; DataIn[31:24] is the next unconsumed byte.
- DataInEnable  in  1  window valid (buffer DataOutEnable).
- DataInEnd  in  1  EOI present in buffer (buffer DataOutEnd).
- UseByte  out  1  consume 8 bits, 1-cycle pulse.
- UseWord  out  1  consume 16 bits, 1-cycle pulse.
- ImageEnable  out  1  entropy-coded segment active (to buffer stuffing logic and decoder).
- SegValid  out  1  SegData/SegMarker valid, 1-cycle pulse.
- SegMarker  out  8  low byte of the current segment marker (e.g. 8'hDB).
- SegData  out  8  payload byte.
- SegFirst  out  1  qualifies the first payload byte of a segment.
- Done  out  1  EOI reached; level, held until DataInStart.
- Error  out  1  protocol error; level, held until DataInStart.

Behaviour:
- Reset (rst=0) or DataInStart=1: state=IDLE; all outputs 0; byte counter Rem=0; marker register=0. DataInStart has priority over every other event. Reset mid-segment abandons the segment with no further SegValid.
- Sampling rule: DataIn is examined only when DataInEnable=1 and no Use* output is high in the same cycle. At most one Use* pulse per sample. Use* are registered and issued the cycle after the sample, which covers the buffer's stale-enable cycle.
- UseByte and UseWord are never high together.
- States:
  - IDLE: next cycle -> SOI.
  - SOI: on sample, if DataIn[31:16]==16'hFFD8, UseWord -> MARK; else Error=1 -> ERR.
  - MARK: on sample:
    - DataIn[31:24]!=8'hFF -> ERR.
    - DataIn[31:16]==16'hFFFF (fill byte) -> UseByte, stay.
    - FFD9 -> UseWord -> DONE.
    - FFD0-FFD7, FF01 (no length) -> UseWord, stay.
    - Otherwise: latch marker=DataIn[23:16], UseWord -> LEN.
  - LEN: on sample, L=DataIn[31:16]:
    - L<2 or L>MAX_LEN -> ERR.
    - Else Rem=L-2, UseWord. If Rem==0: go to IMG when marker==8'hDA, else MARK. If Rem!=0 -> PAY.
  - PAY: on sample:
    - UseByte; Rem decrements by 1.
    - SegValid=1 with SegData=DataIn[31:24] and SegMarker=marker, unless suppressed by SKIP_APP. SegValid and SegData are registered, aligned with the UseByte pulse.
    - SegFirst=1 on the first byte after LEN.
    - When Rem reaches 0: go to IMG if marker==8'hDA, else MARK.
  - IMG: ImageEnable=1 (registered, asserted the cycle after entry). No Use* from this block; the decoder consumes via UseBit. When DataInEnend condition DataInEnd=1: ImageEnable=0 -> MARK. EOI is then consumed by MARK.
  - DONE: Done=1, no Use*, hold.
  - ERR: Error=1, no Use*, ImageEnable=0, hold.
- Rem is 16-bit unsigned and cannot underflow; decrement occurs only when Rem>0.
- DataInEnable=0 stalls any state without side effects.

Test Plan:
- Stream FFD8 FFD9 -> two UseWord pulses, Done=1 two cycles after the second sample, no SegValid, Error=0.
- FFD8, FFDB len 0x0005, bytes 00 11 22 -> 3 SegValid with SegMarker=DB, SegData=00/11/22, SegFirst only on 00; then MARK.
- FFE0 len 0x0004 AA BB with SKIP_APP=1 -> 2 UseByte, zero SegValid; with SKIP_APP=0 -> 2 SegValid with SegMarker=E0.
- FFDA len 0x0002 -> ImageEnable=1 one cycle after LEN; stays high through scan; DataInEnd=1 -> ImageEnable=0, then FFD9 consumed, Done=1.
- Bad stream 12 34 at SOI, or len 0x0001 -> Error=1, no further Use*; DataInStart=1 -> Error=0, state IDLE.
- DataInEnable toggling 1/0 every cycle during PAY, plus rst pulse mid-payload -> exactly one UseByte per valid sample; after reset all outputs 0 and no SegValid.
